vimm_assembler: RTL and testbench

//  Upstream stage of the vector fill unit.
//  - Collects a vector-immediate instruction from the 32-bit instruction stream: one header word plus 1, 2 or 4 payload words.
//  - Presents the assembled imm128 and dtype to the fill stage under a valid/ready handshake.
//  - Drops illegal headers and stalled payloads, flagging them on err.

---
 rtl/vimm_assembler.sv | 126 ++++++++++++
 tb/tb_vimm_assembler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vimm_assembler.sv
// Assembles a vector-immediate instruction (header + 1/2/4 payload words) into imm128/dtype.
// Latency: out_valid one cycle after the last payload word is accepted.
// Backpressure: in_ready low while an assembled result waits for out_ready; flush aborts anything in flight.
module vimm_assembler #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [31:0]  in_word,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] imm128,
  output logic [2:0]   dtype,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);

  // Wait counter only ever holds 0..TIMEOUT-1; hitting the last value with no transfer aborts.
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  state_e         state_q;
  logic [1:0]     idx_q;
  logic [1:0]     last_q;
  logic [WW-1:0]  wait_q;
  logic [127:0]   imm_q;
  logic [2:0]     dtype_q;
  logic           out_valid_q;
  logic           err_q;
  logic           xfer;

  // Index of the final payload word for a legal dtype.
  function automatic logic [1:0] last_idx(input logic [2:0] dt);
    case (dt)
      3'd3:    last_idx = 2'd1;
      3'd4:    last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  endfunction

  assign in_ready  = ((state_q == S_IDLE) || (state_q == S_COLLECT)) && !flush;
  assign xfer      = in_valid && in_ready;
  assign imm128    = imm_q;
  assign dtype     = dtype_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

  // Instruction assembly FSM with registered outputs; flush outranks every state action.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      wait_q      <= '0;
      imm_q       <= '0;
      dtype_q     <= 3'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (flush) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        idx_q       <= 2'd0;
        wait_q      <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (xfer) begin
              if (in_word[2:0] <= 3'd4) begin
                dtype_q <= in_word[2:0];
                last_q  <= last_idx(in_word[2:0]);
                imm_q   <= '0;
                idx_q   <= 2'd0;
                wait_q  <= '0;
                state_q <= S_COLLECT;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_COLLECT: begin
            if (xfer) begin
              imm_q[{idx_q, 5'd0} +: 32] <= in_word;
              idx_q  <= idx_q + 2'd1;
              wait_q <= '0;
              if (idx_q == last_q) begin
                state_q     <= S_OUTPUT;
                out_valid_q <= 1'b1;
              end
            end else if (TIMEOUT != 0) begin
              if (wait_q == WAIT_LAST) begin
                // Stalled payload: drop the partial instruction and report it.
                state_q <= S_IDLE;
                err_q   <= 1'b1;
                idx_q   <= 2'd0;
                wait_q  <= '0;
              end else begin
                wait_q <= wait_q + 1'b1;
              end
            end
          end
          S_OUTPUT: begin
            if (out_valid_q && out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
          default: begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vimm_assembler.sv
// Bench for vimm_assembler: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_vimm_assembler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] imm128;
  logic [2:0]   dtype;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model: words collected so far, how many are needed, pending output.
  bit           m_init = 0;
  bit           m_busy;
  bit           m_pend;
  bit           m_err;
  int           m_need;
  int           m_idle;
  logic [31:0]  got[$];
  logic [127:0] m_imm;
  logic [2:0]   m_dt;

  always #5 clk = ~clk;

  vimm_assembler #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm128    (imm128),
    .dtype     (dtype),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit f, input bit v, input logic [31:0] w,
                            input bit ordy, input bit rdy);
    logic [2:0] hd;
    hd = w[2:0];
    m_err = 0;
    if (!r) begin
      m_init = 1; m_busy = 0; m_pend = 0; m_idle = 0;
      got.delete(); m_imm = '0; m_dt = 3'd0;
    end else if (f) begin
      m_busy = 0; m_pend = 0; m_idle = 0; got.delete();
    end else if (m_pend) begin
      if (ordy) m_pend = 0;
    end else if (!m_busy) begin
      if (v && rdy) begin
        if (hd <= 3'd4) begin
          m_busy = 1; m_dt = hd; m_idle = 0; got.delete();
          m_need = (hd == 3'd4) ? 4 : (hd == 3'd3) ? 2 : 1;
        end else begin
          m_err = 1;
        end
      end
    end else if (v && rdy) begin
      got.push_back(w);
      m_idle = 0;
      if (got.size() == m_need) begin
        m_busy = 0; m_pend = 1; m_imm = '0;
        foreach (got[k]) m_imm = m_imm | ({96'd0, got[k]} << (32 * k));
      end
    end else begin
      m_idle++;
      if (m_idle == 16) begin
        m_busy = 0; m_err = 1; m_idle = 0; got.delete();
      end
    end
  endtask

  // One clock: apply inputs, check in_ready, advance model, check registered outputs.
  task automatic cyc(input bit r, input bit f, input bit v, input logic [31:0] w, input bit ordy);
    bit rdy;
    rst_n = r; flush = f; in_valid = v; in_word = w; out_ready = ordy;
    #1;
    rdy = !m_pend && !f;
    if (m_init && r) chk("in_ready", {127'd0, in_ready}, {127'd0, rdy});
    @(posedge clk);
    model_step(r, f, v, w, ordy, rdy);
    #1;
    chk("out_valid", {127'd0, out_valid}, {127'd0, m_pend});
    chk("err", {127'd0, err}, {127'd0, m_err});
    if (m_pend) begin
      chk("imm128", imm128, m_imm);
      chk("dtype", {125'd0, dtype}, {125'd0, m_dt});
    end
  endtask

  initial begin
    int gap;
    bit v;
    logic [31:0] w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted.
    cyc(0, 0, 1, 32'h0, 0);
    cyc(0, 0, 1, 32'h0, 0);
    chk("rst_imm", imm128, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_ovld", {127'd0, out_valid}, 128'd0);

    // BYTE
    cyc(1, 0, 1, 32'h0, 1);
    cyc(1, 0, 1, 32'h0000_00AB, 1);
    chk("byte_imm", imm128, 128'hAB);
    chk("byte_vld", {127'd0, out_valid}, 128'd1);
    cyc(1, 0, 0, 32'h0, 1);

    // VECTOR with a 3-cycle stall (in_valid kept high to probe in_ready)
    cyc(1, 0, 1, 32'h4, 0);
    cyc(1, 0, 1, 32'h1111_1111, 0);
    cyc(1, 0, 1, 32'h2222_2222, 0);
    cyc(1, 0, 1, 32'h3333_3333, 0);
    cyc(1, 0, 1, 32'h4444_4444, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 32'h5, 0);
      chk("vec_hold", imm128, 128'h44444444_33333333_22222222_11111111);
    end
    cyc(1, 0, 1, 32'h5, 1);
    chk("vec_done", {127'd0, out_valid}, 128'd0);

    // Illegal header, then a WORD
    cyc(1, 0, 1, 32'h7, 1);
    chk("ill_err", {127'd0, err}, 128'd1);
    cyc(1, 0, 1, 32'h2, 1);
    chk("ill_pulse", {127'd0, err}, 128'd0);
    cyc(1, 0, 1, 32'hDEAD_BEEF, 1);
    chk("word_imm", imm128, 128'hDEADBEEF);
    cyc(1, 0, 0, 32'h0, 1);

    // Timeout after one DOUBLEWORD payload
    cyc(1, 0, 1, 32'h3, 1);
    cyc(1, 0, 1, 32'h5555_5555, 1);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 32'h0, 1);
    chk("to_early", {127'd0, err}, 128'd0);
    cyc(1, 0, 0, 32'h0, 1);
    chk("to_err", {127'd0, err}, 128'd1);
    cyc(1, 0, 1, 32'h3, 1);
    cyc(1, 0, 1, 32'hAAAA_0001, 1);
    cyc(1, 0, 1, 32'hBBBB_0002, 1);
    chk("dw_imm", imm128, 128'hBBBB0002_AAAA0001);
    cyc(1, 0, 0, 32'h0, 1);

    // Flush mid-collect, then flush during OUTPUT with out_ready high
    cyc(1, 0, 1, 32'h4, 1);
    cyc(1, 0, 1, 32'h1, 1);
    cyc(1, 0, 1, 32'h2, 1);
    cyc(1, 1, 1, 32'h3, 1);
    cyc(1, 0, 1, 32'h4, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 32'h100 + 32'(i), 0);
    chk("fl_vld", {127'd0, out_valid}, 128'd1);
    cyc(1, 1, 0, 32'h0, 1);
    chk("fl_out", {127'd0, out_valid}, 128'd0);
    chk("fl_err", {127'd0, err}, 128'd0);
    cyc(1, 0, 1, 32'h1, 1);
    cyc(1, 0, 1, 32'hCAFE_F00D, 1);
    chk("fl_after", imm128, 128'hCAFEF00D);
    cyc(1, 0, 0, 32'h0, 1);

    // Random traffic
    gap = 0;
    for (int n = 0; n < 2000; n++) begin
      if (gap == 0 && $urandom_range(0, 59) == 0) gap = $urandom_range(10, 24);
      if (gap > 0) begin
        v = 0;
        gap--;
      end else begin
        v = ($urandom_range(0, 9) < 7);
      end
      w = $urandom;
      cyc(($urandom_range(0, 399) != 0), ($urandom_range(0, 79) == 0), v, w,
          ($urandom_range(0, 9) < 6));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
